// File: rtl/mips_pkg.sv
// Shared fetch-path types: FSM states, datapath widths and the buffered fetch entry.
package mips_pkg;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Drops the byte-offset bits so every fetch address is word aligned.
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch entries. The head entry is kept in its own
// register so the decode-facing outputs come straight from flops and stay
// stable while decode stalls.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_entry,
   input  logic               pop,
   output logic               head_valid,
   output fetch_entry_t       head_entry,
   output logic [CNT_W-1:0]   count
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   fetch_entry_t      mem_q [DEPTH];
   fetch_entry_t      mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   fetch_entry_t      head_q, head_d;
   logic              valid_q, valid_d;
   logic              pop_ok_s;
   logic              push_ok_s;
   logic [PTR_W-1:0]  rd_plus1_s;

   // Next-state for storage, pointers, occupancy and the registered head copy.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      head_d     = head_q;
      rd_plus1_s = rd_ptr_q + PTR_W'(1'b1);
      pop_ok_s   = pop && (count_q != CNT_ZERO) && !flush;
      push_ok_s  = push && !flush && ((count_q != CNT_FULL) || pop_ok_s);

      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_plus1_s;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end

      // The new head is either the incoming entry (buffer was empty or is being
      // drained of its last entry), the next stored entry, or unchanged.
      if (count_d == CNT_ZERO) begin
         head_d = '0;
      end else if ((count_q == CNT_ZERO) || (pop_ok_s && (count_q == CNT_ONE))) begin
         head_d = push_entry;
      end else if (pop_ok_s) begin
         head_d = mem_q[rd_plus1_s];
      end else begin
         head_d = head_q;
      end

      valid_d = (count_d != CNT_ZERO);
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= CNT_ZERO;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   assign head_valid = valid_q;
   assign head_entry = head_q;
   assign count      = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the architectural PC, issues one fetch at a
// time to instruction memory, buffers returned instructions for decode and
// follows redirects from the PC resolution logic. A request already on the bus
// is never withdrawn; a redirect instead marks it to be dropped on return.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [PC_W-1:0]   inst_pc,
   output logic              misalign_err
);

   localparam int CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   req_addr_q, req_addr_d;
   logic [PC_W-1:0]   req_pc_q, req_pc_d;
   logic              req_valid_q, req_valid_d;
   logic              squash_q, squash_d;
   logic              misalign_q, misalign_d;

   logic              accept_s;
   logic              rsp_fire_s;
   logic              push_s;
   logic              pop_s;
   logic              room_s;
   logic [CNT_W-1:0]  count_after_s;
   logic [CNT_W-1:0]  fifo_count_s;
   fetch_entry_t      push_entry_s;
   fetch_entry_t      head_entry_s;

   // Fetch FSM next state, PC update, squash tracking and credit check.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      req_pc_d     = req_pc_q;
      squash_d     = squash_q;
      accept_s     = (state_q == REQ) && imem_req_ready;
      rsp_fire_s   = (state_q == WAIT) && imem_rsp_valid;
      // A response arriving with a redirect is stale by definition.
      push_s       = rsp_fire_s && !squash_q && !redirect_valid;
      pop_s        = inst_ready && inst_valid && !redirect_valid;
      push_entry_s.pc   = req_pc_q;
      push_entry_s.inst = imem_rsp_data;
      misalign_d   = redirect_valid && (redirect_pc[1:0] != 2'b00);

      // Occupancy the buffer will have after this cycle; only one request is
      // ever in flight, so this alone decides whether another may start.
      if (redirect_valid) begin
         count_after_s = CNT_ZERO;
      end else begin
         count_after_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
      end
      room_s = (count_after_s < CNT_FULL);

      case (state_q)
         IDLE: begin
            if (!halt && room_s) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (accept_s) begin
               state_d  = WAIT;
               req_pc_d = req_addr_q;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (rsp_fire_s) begin
               state_d = (!halt && room_s) ? REQ : IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Redirect always wins; a squashed accept must not advance the new PC.
      if (redirect_valid) begin
         pc_d = word_align(redirect_pc);
      end else if (accept_s && !squash_q) begin
         pc_d = req_addr_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end

      // The response consumes any pending squash; a redirect with a request
      // on the bus or in flight marks it for dropping.
      if (rsp_fire_s) begin
         squash_d = 1'b0;
      end else if (redirect_valid && (state_q != IDLE)) begin
         squash_d = 1'b1;
      end else begin
         squash_d = squash_q;
      end

      // Request address is frozen while a request waits for acceptance.
      if ((state_q == REQ) && !accept_s) begin
         req_addr_d = req_addr_q;
      end else begin
         req_addr_d = pc_d;
      end

      req_valid_d = (state_d == REQ);
   end

   // Fetch control registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         req_pc_q    <= RESET_PC;
         req_valid_q <= 1'b0;
         squash_q    <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         squash_q    <= squash_d;
         misalign_q  <= misalign_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_b      (rst_b),
      .flush      (redirect_valid),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head_valid (inst_valid),
      .head_entry (head_entry_s),
      .count      (fifo_count_s)
   );

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = req_addr_q;
   assign inst_data      = head_entry_s.inst;
   assign inst_pc        = head_entry_s.pc;
   assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a simple in-order memory responder.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        misalign_err;

   int tests_run    = 0;
   int tests_failed = 0;

   int          mem_lat = 1;
   bit          pend    = 1'b0;
   int          pend_cnt;
   logic [31:0] pend_addr;

   pc_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Memory: a request seen valid&&ready at a falling edge is accepted at the
   // next rising edge; its response is shown mem_lat falling edges later.
   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      if (!rst_b) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (pend_cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(pend_addr);
               pend           = 1'b0;
            end else begin
               pend_cnt = pend_cnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat - 1;
            pend_addr = imem_req_addr;
         end
      end
   end

   task automatic drive_point();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_reset(input bit hold_halt);
      rst_b          = 1'b0;
      halt           = hold_halt;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b1;
      mem_lat        = 1;
      repeat (2) @(posedge clk);
      #2;
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      rst_b          = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      inst_ready     = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_data  = 32'h0;
      @(negedge clk);
      tests_run += 6;
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      if (imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
      if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
      if (inst_data !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_data: got %h expected 0", inst_data); end
      if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
      if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
   endtask

   task automatic test_sequential_fetch();
      logic [31:0] exp_a [3];
      int n_req;
      int n_pop;
      exp_a = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
      n_req = 0;
      n_pop = 0;
      apply_reset(1'b0);
      inst_ready = 1'b1;
      for (int c = 0; c < 60 && n_pop < 3; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && n_req < 3) begin
            tests_run++;
            if (imem_req_addr !== exp_a[n_req]) begin tests_failed++; $display("FAIL seq_req_addr[%0d]: got %h expected %h", n_req, imem_req_addr, exp_a[n_req]); end
            n_req++;
         end
         if (inst_valid && inst_ready) begin
            tests_run += 2;
            if (inst_pc !== exp_a[n_pop]) begin tests_failed++; $display("FAIL seq_inst_pc[%0d]: got %h expected %h", n_pop, inst_pc, exp_a[n_pop]); end
            if (inst_data !== mem_word(exp_a[n_pop])) begin tests_failed++; $display("FAIL seq_inst_data[%0d]: got %h expected %h", n_pop, inst_data, mem_word(exp_a[n_pop])); end
            n_pop++;
         end
      end
      tests_run++;
      if (n_pop != 3) begin tests_failed++; $display("FAIL seq_timeout: got %0d deliveries expected 3", n_pop); end
   endtask

   task automatic test_decode_stall();
      int n_acc;
      logic [31:0] last_addr;
      apply_reset(1'b0);
      n_acc = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) n_acc++;
      end
      tests_run += 4;
      if (n_acc != 2) begin tests_failed++; $display("FAIL stall_accepts: got %0d expected 2", n_acc); end
      if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_inst_valid: got %b expected 1", inst_valid); end
      if (inst_pc !== RST_PC) begin tests_failed++; $display("FAIL stall_head_pc: got %h expected %h", inst_pc, RST_PC); end
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
      drive_point();
      inst_ready = 1'b1;
      drive_point();
      inst_ready = 1'b0;
      n_acc = 0;
      last_addr = 32'h0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            n_acc++;
            last_addr = imem_req_addr;
         end
      end
      tests_run += 5;
      if (n_acc != 1) begin tests_failed++; $display("FAIL refill_accepts: got %0d expected 1", n_acc); end
      if (last_addr !== 32'h0040_0008) begin tests_failed++; $display("FAIL refill_addr: got %h expected 00400008", last_addr); end
      if (inst_pc !== 32'h0040_0004) begin tests_failed++; $display("FAIL refill_head_pc: got %h expected 00400004", inst_pc); end
      if (inst_data !== mem_word(32'h0040_0004)) begin tests_failed++; $display("FAIL refill_head_data: got %h expected %h", inst_data, mem_word(32'h0040_0004)); end
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL refill_req_valid: got %b expected 0", imem_req_valid); end
   endtask

   task automatic test_redirect_wait();
      bit found;
      bit got_req;
      bit got_inst;
      apply_reset(1'b0);
      mem_lat    = 3;
      inst_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h0040_0008) found = 1'b1;
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("FAIL rwait_find_req: got none expected accept of 00400008"); end
      drive_point();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1000;
      drive_point();
      redirect_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rwait_flush: got inst_valid %b expected 0", inst_valid); end
      got_req  = 1'b0;
      got_inst = 1'b0;
      for (int c = 0; c < 60 && !got_inst; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && !got_req) begin
            got_req = 1'b1;
            tests_run++;
            if (imem_req_addr !== 32'h0000_1000) begin tests_failed++; $display("FAIL rwait_next_addr: got %h expected 00001000", imem_req_addr); end
         end
         if (inst_valid && inst_ready) begin
            got_inst = 1'b1;
            tests_run += 2;
            if (inst_pc !== 32'h0000_1000) begin tests_failed++; $display("FAIL rwait_inst_pc: got %h expected 00001000", inst_pc); end
            if (inst_data !== mem_word(32'h0000_1000)) begin tests_failed++; $display("FAIL rwait_inst_data: got %h expected %h", inst_data, mem_word(32'h0000_1000)); end
         end
      end
      tests_run++;
      if (!got_inst) begin tests_failed++; $display("FAIL rwait_timeout: got no delivery expected one"); end
   endtask

   task automatic test_redirect_req_stall();
      bit found;
      bit got_req;
      bit got_inst;
      apply_reset(1'b0);
      inst_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && imem_req_addr == RST_PC) found = 1'b1;
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("FAIL rreq_find_req: got none expected accept of %h", RST_PC); end
      drive_point();
      imem_req_ready = 1'b0;
      drive_point();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run += 2;
         if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rreq_hold_valid[%0d]: got %b expected 1", i, imem_req_valid); end
         if (imem_req_addr !== 32'h0040_0004) begin tests_failed++; $display("FAIL rreq_hold_addr[%0d]: got %h expected 00400004", i, imem_req_addr); end
         if (i > 0) begin
            tests_run++;
            if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rreq_flush[%0d]: got inst_valid %b expected 0", i, inst_valid); end
         end
         drive_point();
         redirect_valid = 1'b0;
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (!(imem_req_valid === 1'b1 && imem_req_addr === 32'h0040_0004)) begin tests_failed++; $display("FAIL rreq_accept_old: got valid %b addr %h expected 1 00400004", imem_req_valid, imem_req_addr); end
      got_req  = 1'b0;
      got_inst = 1'b0;
      for (int c = 0; c < 40 && !got_inst; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && !got_req) begin
            got_req = 1'b1;
            tests_run++;
            if (imem_req_addr !== 32'h0000_3000) begin tests_failed++; $display("FAIL rreq_next_addr: got %h expected 00003000", imem_req_addr); end
         end
         if (inst_valid && inst_ready) begin
            got_inst = 1'b1;
            tests_run++;
            if (inst_pc !== 32'h0000_3000) begin tests_failed++; $display("FAIL rreq_inst_pc: got %h expected 00003000", inst_pc); end
         end
      end
      tests_run++;
      if (!got_inst) begin tests_failed++; $display("FAIL rreq_timeout: got no delivery expected one"); end
   endtask

   task automatic test_misalign();
      apply_reset(1'b1);
      drive_point();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2002;
      @(negedge clk);
      tests_run++;
      if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL mis_early: got %b expected 0", misalign_err); end
      drive_point();
      redirect_valid = 1'b0;
      @(negedge clk);
      tests_run += 2;
      if (misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse: got %b expected 1", misalign_err); end
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_halt_req: got %b expected 0", imem_req_valid); end
      drive_point();
      halt = 1'b0;
      @(negedge clk);
      tests_run++;
      if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
      drive_point();
      @(negedge clk);
      tests_run += 2;
      if (imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL mis_req_valid: got %b expected 1", imem_req_valid); end
      if (imem_req_addr !== 32'h0000_2000) begin tests_failed++; $display("FAIL mis_req_addr: got %h expected 00002000", imem_req_addr); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] exp_a [2];
      int n_req;
      exp_a = '{32'hFFFF_FFFC, 32'h0000_0000};
      n_req = 0;
      apply_reset(1'b1);
      inst_ready = 1'b1;
      drive_point();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      drive_point();
      redirect_valid = 1'b0;
      halt           = 1'b0;
      for (int c = 0; c < 30 && n_req < 2; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            tests_run++;
            if (imem_req_addr !== exp_a[n_req]) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got %h expected %h", n_req, imem_req_addr, exp_a[n_req]); end
            n_req++;
         end
      end
      tests_run++;
      if (n_req != 2) begin tests_failed++; $display("FAIL wrap_timeout: got %0d requests expected 2", n_req); end
   endtask

   task automatic test_reset_mid_op();
      bit found;
      bit got_req;
      bit got_inst;
      apply_reset(1'b0);
      mem_lat = 3;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h0040_0004) found = 1'b1;
      end
      tests_run++;
      if (!found) begin tests_failed++; $display("FAIL rmid_find_req: got none expected accept of 00400004"); end
      drive_point();
      tests_run++;
      if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_valid: got %b expected 1", inst_valid); end
      rst_b = 1'b0;
      #1;
      tests_run += 6;
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_req_valid: got %b expected 0", imem_req_valid); end
      if (imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL rmid_req_addr: got %h expected %h", imem_req_addr, RST_PC); end
      if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_inst_valid: got %b expected 0", inst_valid); end
      if (inst_data !== 32'h0) begin tests_failed++; $display("FAIL rmid_inst_data: got %h expected 0", inst_data); end
      if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL rmid_inst_pc: got %h expected 0", inst_pc); end
      if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL rmid_misalign: got %b expected 0", misalign_err); end
      repeat (2) @(posedge clk);
      #2;
      mem_lat    = 1;
      inst_ready = 1'b1;
      rst_b      = 1'b1;
      got_req  = 1'b0;
      got_inst = 1'b0;
      for (int c = 0; c < 30 && !got_inst; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && !got_req) begin
            got_req = 1'b1;
            tests_run++;
            if (imem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL rmid_first_addr: got %h expected %h", imem_req_addr, RST_PC); end
         end
         if (inst_valid && inst_ready) begin
            got_inst = 1'b1;
            tests_run += 2;
            if (inst_pc !== RST_PC) begin tests_failed++; $display("FAIL rmid_first_pc: got %h expected %h", inst_pc, RST_PC); end
            if (inst_data !== mem_word(RST_PC)) begin tests_failed++; $display("FAIL rmid_first_data: got %h expected %h", inst_data, mem_word(RST_PC)); end
         end
      end
      tests_run++;
      if (!got_inst) begin tests_failed++; $display("FAIL rmid_timeout: got no delivery expected one"); end
   endtask

   initial begin
      test_reset();
      test_sequential_fetch();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_req_stall();
      test_misalign();
      test_pc_wrap();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
